// File: rtl/instr_responder.sv
// Fetch-handshake responder: serves one addressed word per syn/ack transaction
// from a preloadable instruction memory that tracks the program length.
module instr_responder #(
  parameter int               IWIDTH   = 32,
  parameter int               DEPTH    = 36,
  parameter int               PC_WIDTH = 32,
  parameter int               LWIDTH   = 6,
  parameter logic [IWIDTH-1:0] NOP     = 32'h0000_0013
) (
  input  logic                ir_clk,
  input  logic                ir_rst,
  input  logic                ir_i_syn,
  input  logic [PC_WIDTH-1:0] ir_i_addr,
  output logic [IWIDTH-1:0]   ir_o_instr,
  output logic                ir_o_ack,
  output logic                ir_o_last,
  output logic                ir_o_err,
  input  logic                ir_i_wr_en,
  input  logic [LWIDTH-1:0]   ir_i_wr_addr,
  input  logic [IWIDTH-1:0]   ir_i_wr_data,
  input  logic                ir_i_clear,
  output logic [LWIDTH-1:0]   ir_o_len
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ACK
  } state_t;

  localparam logic [LWIDTH-1:0] L_DEPTH = LWIDTH'(DEPTH);
  localparam logic [LWIDTH-1:0] L_ONE   = LWIDTH'(1);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_addr;
  logic [IWIDTH-1:0]   r_mem [DEPTH];
  logic [IWIDTH-1:0]   r_instr;
  logic                r_ack;
  logic                r_last;
  logic                r_err;
  logic [LWIDTH-1:0]   r_len;

  logic [LWIDTH-1:0]   w_idx;
  logic                w_hi;
  logic                w_mis;
  logic                w_oor;
  logic                w_wr_ok;
  logic [LWIDTH-1:0]   w_wr_next;

  assign w_idx     = r_addr[LWIDTH+1:2];
  assign w_hi      = |r_addr[PC_WIDTH-1:LWIDTH+2];
  assign w_mis     = |r_addr[1:0];
  assign w_oor     = w_hi || (w_idx >= r_len) || (w_idx >= L_DEPTH);
  assign w_wr_ok   = ir_i_wr_en && (ir_i_wr_addr < L_DEPTH);
  assign w_wr_next = ir_i_wr_addr + L_ONE;

  // Storage is deliberately left unreset; len gates every read.
  always_ff @(posedge ir_clk) begin
    if (w_wr_ok) begin
      r_mem[ir_i_wr_addr] <= ir_i_wr_data;
    end
  end

  always_ff @(posedge ir_clk or negedge ir_rst) begin
    if (!ir_rst) begin
      r_len <= '0;
    end else if (ir_i_clear) begin
      r_len <= '0;
    end else if (w_wr_ok && (w_wr_next > r_len)) begin
      r_len <= w_wr_next;
    end
  end

  always_ff @(posedge ir_clk or negedge ir_rst) begin
    if (!ir_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_instr <= '0;
      r_ack   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ir_i_syn) begin
            r_addr  <= ir_i_addr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_ack   <= 1'b1;
          r_state <= S_ACK;
          if (w_mis) begin
            r_instr <= NOP;
            r_err   <= 1'b1;
            r_last  <= 1'b0;
          end else if (w_oor) begin
            r_instr <= NOP;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
          end else begin
            r_instr <= r_mem[w_idx];
            r_err   <= 1'b0;
            r_last  <= (w_idx == (r_len - L_ONE));
          end
        end
        S_ACK: begin
          if (!ir_i_syn) begin
            r_ack   <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ir_o_instr = r_instr;
  assign ir_o_ack   = r_ack;
  assign ir_o_last  = r_last;
  assign ir_o_err   = r_err;
  assign ir_o_len   = r_len;

endmodule

// File: tb/tb_instr_responder.sv
// Bench for instr_responder: vector table of fetches plus hand sequences
// for same-edge writes, protocol violations and async reset.
module tb_instr_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        last;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        syn;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        ack;
  logic        last;
  logic        err;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear;
  logic [5:0]  len;

  int n_checks;
  int n_errors;
  exp_t sb[$];
  vec_t tbl[8];

  instr_responder dut (
    .ir_clk      (clk),
    .ir_rst      (rst_n),
    .ir_i_syn    (syn),
    .ir_i_addr   (addr),
    .ir_o_instr  (instr),
    .ir_o_ack    (ack),
    .ir_o_last   (last),
    .ir_o_err    (err),
    .ir_i_wr_en  (wr_en),
    .ir_i_wr_addr(wr_addr),
    .ir_i_wr_data(wr_data),
    .ir_i_clear  (clear),
    .ir_o_len    (len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d,
                    input logic clr);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    clear   = clr;
    @(negedge clk);
    wr_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_resp(input string nm);
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty got %h", nm, instr);
      return;
    end
    x = sb.pop_front();
    chk({nm, "_instr"}, instr, x.instr);
    chk({nm, "_last"}, {31'b0, last}, {31'b0, x.last});
    chk({nm, "_err"}, {31'b0, err}, {31'b0, x.err});
  endtask

  task automatic fetch(input logic [31:0] a, input exp_t e, input int hold);
    int n;
    logic [31:0] held;
    sb.push_back(e);
    syn  = 1'b1;
    addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    chk("ack_latency", n, 2);
    held = instr;
    check_resp("fetch");
    for (int h = 0; h < hold; h++) begin
      addr = $urandom;
      @(negedge clk);
      chk("hold_ack", {31'b0, ack}, 32'd1);
      chk("hold_instr", instr, e.instr);
    end
    syn = 1'b0;
    @(negedge clk);
    chk("ack_drop", {31'b0, ack}, 32'd0);
    chk("last_drop", {31'b0, last}, 32'd0);
    chk("err_drop", {31'b0, err}, 32'd0);
    chk("instr_kept", instr, held);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    syn     = 1'b0;
    addr    = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clear   = 1'b0;

    tbl[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0020_81B3, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_000C, 32'h0000_006F, 1'b1, 1'b0};
    tbl[4] = '{32'h0000_0010, NOP,           1'b1, 1'b0};
    tbl[5] = '{32'h0000_0006, NOP,           1'b0, 1'b1};
    tbl[6] = '{32'h0000_0100, NOP,           1'b1, 1'b0};
    tbl[7] = '{32'h0000_0090, NOP,           1'b1, 1'b0};

    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_last", {31'b0, last}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_len", {26'b0, len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fetch(32'h0, '{NOP, 1'b1, 1'b0}, 0);
    chk("empty_len", {26'b0, len}, 32'd0);

    wr(6'd0, 32'h0050_0093, 1'b0);
    wr(6'd1, 32'h00A0_0113, 1'b0);
    wr(6'd2, 32'h0020_81B3, 1'b0);
    wr(6'd3, 32'h0000_006F, 1'b0);
    chk("preload_len", {26'b0, len}, 32'd4);
    wr(6'd40, 32'hFFFF_FFFF, 1'b0);
    chk("oob_write_len", {26'b0, len}, 32'd4);
    wr(6'd1, 32'h00A0_0113, 1'b0);
    chk("rewrite_len", {26'b0, len}, 32'd4);

    for (int i = 0; i < 8; i++) begin
      fetch(tbl[i].addr, '{tbl[i].instr, tbl[i].last, tbl[i].err}, 0);
    end

    // Write lands on the same edge as the READ of index 2.
    sb.push_back('{32'h0020_81B3, 1'b0, 1'b0});
    syn  = 1'b1;
    addr = 32'h8;
    @(negedge clk);
    chk("rbw_read_noack", {31'b0, ack}, 32'd0);
    wr_en   = 1'b1;
    wr_addr = 6'd2;
    wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rbw_ack", {31'b0, ack}, 32'd1);
    check_resp("rbw");
    syn = 1'b0;
    @(negedge clk);
    chk("rbw_drop", {31'b0, ack}, 32'd0);
    fetch(32'h8, '{32'hDEAD_BEEF, 1'b0, 1'b0}, 0);

    // syn withdrawn during READ: still acked once.
    sb.push_back('{32'h00A0_0113, 1'b0, 1'b0});
    syn  = 1'b1;
    addr = 32'h4;
    @(negedge clk);
    syn = 1'b0;
    @(negedge clk);
    chk("viol_ack", {31'b0, ack}, 32'd1);
    check_resp("viol");
    @(negedge clk);
    chk("viol_drop", {31'b0, ack}, 32'd0);

    fetch(32'hC, '{32'h0000_006F, 1'b1, 1'b0}, 5);

    wr(6'd5, 32'h1234_5678, 1'b1);
    chk("clear_len", {26'b0, len}, 32'd0);
    fetch(32'h14, '{NOP, 1'b1, 1'b0}, 0);

    wr(6'd0, 32'h0050_0093, 1'b0);
    chk("relen", {26'b0, len}, 32'd1);
    sb.push_back('{32'h0050_0093, 1'b1, 1'b0});
    syn  = 1'b1;
    addr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ack", {31'b0, ack}, 32'd1);
    check_resp("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'b0, ack}, 32'd0);
    chk("arst_last", {31'b0, last}, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_len", {26'b0, len}, 32'd0);
    syn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h0, '{NOP, 1'b1, 1'b0}, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
